// File: rtl/alu_decoder.sv
// ALU control decoder: maps the main-decoder class (ALUOp) plus the funct3,
// funct7[5] and opcode[5] instruction bits onto a 3-bit ALU operation code
// and an illegal-combination flag.
//
// Parameter REG_OUT selects registered (1, one cycle of latency, load enable
// en, synchronous active-low reset) or purely combinational (0) outputs.
//
// Optional feature macro: ALU_DECODER_XOR_EN
//   defined   -> ALUOp=10, funct3=100 decodes to xor (100)
//   undefined -> that combination is illegal and code 100 is never produced
module alu_decoder #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       op5,
  input  logic       funct7,
  input  logic [2:0] funct3,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [2:0] dec_ctrl;
  logic       dec_ill;
  logic [2:0] ctrl_d;
  logic [2:0] ctrl_q;
  logic       ill_d;
  logic       ill_q;

  // Pure combinational decode of the current instruction fields
  always_comb begin
    dec_ctrl = ALU_ADD;
    dec_ill  = 1'b0;
    unique case (ALUOp)
      2'b00: dec_ctrl = ALU_ADD;
      2'b01: dec_ctrl = ALU_SUB;
      2'b10: begin
        unique case (funct3)
          // Only R-type with funct7[5] set is sub; addi ignores the immediate bit
          3'b000: dec_ctrl = (op5 && funct7) ? ALU_SUB : ALU_ADD;
          3'b010: dec_ctrl = ALU_SLT;
          3'b110: dec_ctrl = ALU_OR;
          3'b111: dec_ctrl = ALU_AND;
`ifdef ALU_DECODER_XOR_EN
          3'b100: dec_ctrl = ALU_XOR;
`else
          3'b100: begin
            dec_ctrl = ALU_ADD;
            dec_ill  = 1'b1;
          end
`endif
          default: begin
            dec_ctrl = ALU_ADD;
            dec_ill  = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctrl = ALU_ADD;
        dec_ill  = 1'b1;
      end
    endcase
  end

  // Next-state for the output register: load on en, otherwise hold
  always_comb begin
    ctrl_d = ctrl_q;
    ill_d  = ill_q;
    if (en) begin
      ctrl_d = dec_ctrl;
      ill_d  = dec_ill;
    end
  end

  // Output register; reset wins over the load enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= ALU_ADD;
      ill_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      ill_q  <= ill_d;
    end
  end

  // Output timing select; the unused path is trimmed at elaboration
  always_comb begin
    if (REG_OUT) begin
      ALUControl = ctrl_q;
      illegal    = ill_q;
    end else begin
      ALUControl = dec_ctrl;
      illegal    = dec_ill;
    end
  end

endmodule

// File: tb/tb_alu_decoder.sv
// Bench for alu_decoder: a registered instance (REG_OUT=1) and a
// combinational instance (REG_OUT=0) share the same stimulus.
module tb_alu_decoder;

`ifdef ALU_DECODER_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       op5;
  logic       funct7;
  logic [2:0] funct3;
  logic [1:0] ALUOp;
  logic [2:0] ctrl_r;
  logic       ill_r;
  logic [2:0] ctrl_c;
  logic       ill_c;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_reg;

  alu_decoder #(.REG_OUT(1'b1)) dut_reg (
    .clk(clk), .rst_n(rst_n), .en(en), .op5(op5), .funct7(funct7),
    .funct3(funct3), .ALUOp(ALUOp), .ALUControl(ctrl_r), .illegal(ill_r)
  );

  alu_decoder #(.REG_OUT(1'b0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .en(en), .op5(op5), .funct7(funct7),
    .funct3(funct3), .ALUOp(ALUOp), .ALUControl(ctrl_c), .illegal(ill_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ALUControl, illegal} from the instruction-class rules
  function automatic logic [3:0] model(logic [1:0] aluop, logic [2:0] f3,
                                       logic f7, logic o5);
    int op;
    bit bad;
    op  = 0;
    bad = 0;
    if (aluop == 2'd0)      op = 0;
    else if (aluop == 2'd1) op = 1;
    else if (aluop == 2'd3) bad = 1;
    else begin
      if (f3 == 3'd0)                op = (o5 && f7) ? 1 : 0;
      else if (f3 == 3'd2)           op = 5;
      else if (f3 == 3'd6)           op = 3;
      else if (f3 == 3'd7)           op = 2;
      else if (f3 == 3'd4 && XOR_EN) op = 4;
      else                           bad = 1;
    end
    return {op[2:0], bad};
  endfunction

  task automatic check(string name, logic [2:0] act_c, logic act_i,
                       logic [3:0] exp);
    checks++;
    if ({act_c, act_i} !== exp) begin
      errors++;
      $display("FAIL %s: got ctrl=%b ill=%b, expected ctrl=%b ill=%b",
               name, act_c, act_i, exp[3:1], exp[0]);
    end
  endtask

  // Drive one cycle: comb output checked before the edge, reg output after
  task automatic step(string name, logic [1:0] a, logic [2:0] f3, logic f7,
                      logic o5, logic en_v, logic rst_v);
    logic [3:0] m;
    @(negedge clk);
    ALUOp = a; funct3 = f3; funct7 = f7; op5 = o5; en = en_v; rst_n = rst_v;
    m = model(a, f3, f7, o5);
    #1;
    check({name, "_comb"}, ctrl_c, ill_c, m);
    @(posedge clk);
    if (!rst_v)    exp_reg = 4'b0000;
    else if (en_v) exp_reg = m;
    #1;
    check({name, "_reg"}, ctrl_r, ill_r, exp_reg);
  endtask

  typedef struct {
    logic [1:0] aluop;
    logic [2:0] f3;
    logic       f7;
    logic       o5;
    logic [2:0] ctrl;
    logic       ill;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [3:0] held;
    logic [1:0] ra;
    logic [2:0] rf3;
    logic       rf7, ro5, ren, rrst;

    rst_n = 1'b1; en = 1'b1; op5 = 1'b0; funct7 = 1'b0;
    funct3 = 3'd0; ALUOp = 2'b11;
    exp_reg = 4'b0000;

    // Load a non-zero value so the reset check shows a real change
    step("preload_ill", 2'b11, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset held two clocks with en=1 and ALUOp=01: reset wins
    step("reset1", 2'b01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("reset2", 2'b01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_value", ctrl_r, ill_r, 4'b0000);
    // First edge after reset release loads the decode
    step("post_reset_load", 2'b01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("post_reset_sub", ctrl_r, ill_r, 4'b0010);

    vecs[0]  = '{2'b00, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0};
    vecs[1]  = '{2'b01, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0};
    vecs[2]  = '{2'b00, 3'b111, 1'b1, 1'b1, 3'b000, 1'b0};
    vecs[3]  = '{2'b01, 3'b110, 1'b1, 1'b1, 3'b001, 1'b0};
    vecs[4]  = '{2'b10, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0};
    vecs[5]  = '{2'b10, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0};
    vecs[6]  = '{2'b10, 3'b010, 1'b0, 1'b1, 3'b101, 1'b0};
    vecs[7]  = '{2'b10, 3'b110, 1'b0, 1'b1, 3'b011, 1'b0};
    vecs[8]  = '{2'b10, 3'b111, 1'b0, 1'b1, 3'b010, 1'b0};
    vecs[9]  = '{2'b10, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
    vecs[10] = '{2'b10, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0};
    vecs[11] = '{2'b11, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1};
    vecs[12] = '{2'b10, 3'b001, 1'b0, 1'b1, 3'b000, 1'b1};
    vecs[13] = '{2'b10, 3'b101, 1'b1, 1'b1, 3'b000, 1'b1};
    vecs[14] = XOR_EN ? '{2'b10, 3'b100, 1'b0, 1'b1, 3'b100, 1'b0}
                      : '{2'b10, 3'b100, 1'b0, 1'b1, 3'b000, 1'b1};

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ALUOp = vecs[i].aluop; funct3 = vecs[i].f3; funct7 = vecs[i].f7;
      op5 = vecs[i].o5; en = 1'b1; rst_n = 1'b1;
      #1;
      check($sformatf("vec%0d_comb", i), ctrl_c, ill_c, {vecs[i].ctrl, vecs[i].ill});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_reg", i), ctrl_r, ill_r, {vecs[i].ctrl, vecs[i].ill});
      exp_reg = {vecs[i].ctrl, vecs[i].ill};
    end

    // Enable low: load slt, then change inputs with en=0 and expect a hold
    step("load_slt", 2'b10, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1);
    held = {ctrl_r, ill_r};
    step("hold1", 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    step("hold2", 2'b00, 3'b111, 1'b1, 1'b1, 1'b0, 1'b1);
    check("hold_value", ctrl_r, ill_r, 4'b1010);
    check("hold_same", ctrl_r, ill_r, held);

    // Combinational instance follows inputs with no clock edge in between
    @(posedge clk);
    #1;
    ALUOp = 2'b10; op5 = 1'b1; funct7 = 1'b1; funct3 = 3'b000;
    en = 1'b0; rst_n = 1'b0;
    #1;
    check("comb_zero_latency_sub", ctrl_c, ill_c, 4'b0010);
    ALUOp = 2'b11;
    #1;
    check("comb_zero_latency_ill", ctrl_c, ill_c, 4'b0001);
    @(posedge clk);
    exp_reg = 4'b0000;
    #1;
    check("reset_under_en0", ctrl_r, ill_r, exp_reg);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      ra   = 2'($urandom_range(0, 3));
      rf3  = 3'($urandom_range(0, 7));
      rf7  = 1'($urandom_range(0, 1));
      ro5  = 1'($urandom_range(0, 1));
      ren  = ($urandom_range(0, 3) != 0);
      rrst = ($urandom_range(0, 19) != 0);
      step($sformatf("rand%0d", i), ra, rf3, rf7, ro5, ren, rrst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_decoder.md
ALU_DECODER -- requirements
Module: alu_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter REG_OUT, default 1, SHALL select output timing: 1 = registered outputs, 0 = combinational outputs.
REQ-003 Port clk, input, 1, SHALL be the rising-edge clock.
REQ-004 Port rst_n, input, 1, SHALL be the synchronous active-low reset.
REQ-005 Port en, input, 1, SHALL be the output-register load enable.
REQ-006 Port op5, input, 1, SHALL be opcode bit 5 (1 = R-type, 0 = I-type).
REQ-007 Port funct7, input, 1, SHALL be instruction funct7 bit 5.
REQ-008 Port funct3, input, 3, SHALL be the instruction funct3 field.
REQ-009 Port ALUOp, input, 2, SHALL be the main-decoder class: 00 = load/store, 01 = branch, 10 = arithmetic, 11 = reserved.
REQ-010 Port ALUControl, output, 3, SHALL be the ALU operation code: 000 = add, 001 = sub, 010 = and, 011 = or, 100 = xor, 101 = slt.
REQ-011 Port illegal, output, 1, SHALL flag an undecodable combination.

Function
REQ-012 ALUOp=00 SHALL decode to ALUControl=000 (add), illegal=0, for any funct3/funct7/op5.
REQ-013 ALUOp=01 SHALL decode to ALUControl=001 (sub), illegal=0, for any funct3/funct7/op5.
REQ-014 ALUOp=10 with funct3=000 SHALL decode to 001 (sub) only when op5=1 and funct7=1, and to 000 (add) otherwise.
REQ-015 In REQ-014, op5=0 with funct7=1 (addi with a set immediate bit) SHALL decode to add.
REQ-016 ALUOp=10 with funct3=010 SHALL decode to 101 (slt).
REQ-017 ALUOp=10 with funct3=110 SHALL decode to 011 (or).
REQ-018 ALUOp=10 with funct3=111 SHALL decode to 010 (and).
REQ-019 ALUOp=10 with funct3 in {001, 011, 101}, and with funct3=100 when XOR is disabled, SHALL decode to 000 with illegal=1.
REQ-020 ALUOp=11 SHALL decode to 000 with illegal=1.
REQ-021 With REG_OUT=1, ALUControl and illegal SHALL update on the rising clk edge when en=1, giving exactly one cycle of latency.
REQ-022 With REG_OUT=1, the outputs SHALL hold their value when en=0.
REQ-023 With REG_OUT=0, ALUControl and illegal SHALL follow the inputs combinationally, with zero latency.
REQ-024 With REG_OUT=0, en and the clock SHALL have no effect on the outputs.
REQ-025 The decode SHALL be a pure function of the current inputs, with no further state.

Reset
REQ-026 With REG_OUT=1, rst_n=0 at a rising clk edge SHALL force ALUControl=000 and illegal=0.
REQ-027 Reset SHALL take priority over en.
REQ-028 The first edge after rst_n returns to 1 SHALL load the decoded value if en=1.
REQ-029 With REG_OUT=0, reset SHALL have no effect.

Configuration
REQ-030 When macro ALU_DECODER_XOR_EN is defined, ALUOp=10 with funct3=100 SHALL decode to 100 (xor), illegal=0.
REQ-031 When ALU_DECODER_XOR_EN is not defined, that combination SHALL decode to 000 with illegal=1, and code 100 SHALL never be produced.

Verification
REQ-032 The bench SHALL check reset: rst_n=0 for 2 clocks with en=1 and ALUOp=01 -> ALUControl=000, illegal=0.
REQ-033 The bench SHALL check load/store and branch: ALUOp=00, funct3=000 -> 000; then ALUOp=01 -> 001; each valid one clock after being applied.
REQ-034 The bench SHALL check R-type decode with ALUOp=10:
- op5=0, funct7=0, funct3=000 -> 000
- op5=1, funct7=1, funct3=000 -> 001
- funct3=010 -> 101
- funct3=110 -> 011
- funct3=111 -> 010
REQ-035 The bench SHALL check the add/sub corner: ALUOp=10, funct3=000, op5=0, funct7=1 -> 000; then op5=1, funct7=0 -> 000.
REQ-036 The bench SHALL check illegal and enable behaviour:
- ALUOp=11 -> 000 with illegal=1.
- ALUOp=10, funct3=100 -> 100 with illegal=0 when ALU_DECODER_XOR_EN is defined, else 000 with illegal=1.
- With en=0, changing the inputs SHALL leave the outputs unchanged.
REQ-037 The bench SHALL check REG_OUT=0: ALUOp=10, op5=1, funct7=1, funct3=000 -> ALUControl=001 in the same time step, with no clock edge.
